// File: rtl/datapath_core_p_if.sv
// -----------------------------------------------------------------------------
// datapath_core_p_if
// Control-side bundle of the datapath: register load/drive strobes, the Y/Z/HI/LO
// load enables, the external bus source, operation select, and the observable
// outputs (bus, conflict, engine status, Z contents).
//   master : control unit side (drives strobes, observes status)
//   slave  : datapath side
// -----------------------------------------------------------------------------
interface datapath_core_p_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    logic [NREGS-1:0] reg_in;
    logic [NREGS-1:0] reg_out;
    logic             ba_out;
    logic             y_in;
    logic             z_in;
    logic             hi_in;
    logic             lo_in;
    logic             zhi_out;
    logic             zlo_out;
    logic             hi_out;
    logic             lo_out;
    logic             ext_out_en;
    logic [WIDTH-1:0] ext_in;
    logic [2:0]       op;
    logic             start;
    logic [WIDTH-1:0] bus;
    logic             bus_conflict;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] zhi_q;
    logic [WIDTH-1:0] zlo_q;

    modport master (
        output reg_in, reg_out, ba_out, y_in, z_in, hi_in, lo_in,
               zhi_out, zlo_out, hi_out, lo_out, ext_out_en, ext_in, op, start,
        input  bus, bus_conflict, busy, done, div0, zhi_q, zlo_q
    );

    modport slave (
        input  reg_in, reg_out, ba_out, y_in, z_in, hi_in, lo_in,
               zhi_out, zlo_out, hi_out, lo_out, ext_out_en, ext_in, op, start,
        output bus, bus_conflict, busy, done, div0, zhi_q, zlo_q
    );
endinterface

// File: rtl/datapath_core_p.sv
// -----------------------------------------------------------------------------
// datapath_core_p
// Single-bus CPU datapath: NREGS x WIDTH register bank, Y, Z (ZHI/ZLO), HI, LO,
// a single-cycle ALU (ADD/SUB/AND/OR) and an iterative signed MUL/DIV engine.
// Ports:
//   clk  : clock, rising edge
//   clr  : synchronous active-high reset
//   dp   : datapath_core_p_if.slave (strobes in; bus, status and Z out)
// -----------------------------------------------------------------------------
module datapath_core_p #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic            clk,
    input  logic            clr,
    datapath_core_p_if.slave dp
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam int NSRC = NREGS + 5;
    localparam int CW   = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] y_q, hi_q, lo_q, zhi_r, zlo_r;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             busy_r, done_r, div0_r;

    // Engine operands: magnitudes, signs, raw dividend, and the working pair
    // (product hi/lo for MUL, remainder/quotient for DIV).
    logic             eng_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_raw, mag_a, mag_b, acc_hi, acc_lo;

    logic [NSRC-1:0]  req;
    logic [WIDTH-1:0] bus_w, alu;
    logic             launch, z_load;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // ---------------- bus source selection ----------------
    // Priority order R0..R(N-1), HI, LO, ZHI, ZLO, EXT; lowest index wins.
    assign req = {dp.ext_out_en, dp.zlo_out, dp.zhi_out, dp.lo_out, dp.hi_out, dp.reg_out};

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bus_w = '0;
        if (dp.reg_out[0]) begin
            bus_w = dp.ba_out ? '0 : regs[0];
        end else if (|dp.reg_out) begin
            // Descending scan so the lowest active index is written last.
            for (int i = NREGS - 1; i >= 1; i--) begin
                if (dp.reg_out[i]) bus_w = regs[i];
            end
        end else if (dp.hi_out) begin
            bus_w = hi_q;
        end else if (dp.lo_out) begin
            bus_w = lo_q;
        end else if (dp.zhi_out) begin
            bus_w = zhi_r;
        end else if (dp.zlo_out) begin
            bus_w = zlo_r;
        end else if (dp.ext_out_en) begin
            bus_w = dp.ext_in;
        end
    end

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign dp.bus_conflict = |(req & (req - NSRC'(1)));
    assign dp.bus          = bus_w;

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        case (dp.op)
            OP_SUB:  alu = y_q - bus_w;
            OP_AND:  alu = y_q & bus_w;
            OP_OR:   alu = y_q | bus_w;
            default: alu = y_q + bus_w;   // ADD and reserved codes
        endcase
    end

    assign launch = dp.start && !busy_r && (dp.op == OP_MUL || dp.op == OP_DIV);
    assign z_load = dp.z_in && !busy_r && !(dp.op == OP_MUL || dp.op == OP_DIV);

    // ---------------- engine iteration and sign fix-up ----------------
    // MUL: shift-add, multiplier bits consumed from acc_lo LSB first.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    // DIV: restoring division, dividend bits enter the remainder MSB first.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    assign prod = (a_neg ^ b_neg) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo  = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
    assign rem  = a_neg ? -acc_hi : acc_hi;   // remainder follows the dividend

    // ---------------- state ----------------
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: the register bank is architecturally cleared by clr, so it is
            // built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            zhi_r   <= '0;
            zlo_r   <= '0;
            state   <= S_IDLE;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
            eng_div <= 1'b0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            a_raw   <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done_r <= 1'b0;

            for (int i = 0; i < NREGS; i++) begin
                if (dp.reg_in[i]) regs[i] <= bus_w;
            end
            if (dp.y_in)  y_q  <= bus_w;
            if (dp.hi_in) hi_q <= bus_w;
            if (dp.lo_in) lo_q <= bus_w;

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        eng_div <= (dp.op == OP_DIV);
                        a_neg   <= y_q[WIDTH-1];
                        b_neg   <= bus_w[WIDTH-1];
                        a_raw   <= y_q;
                        mag_a   <= y_q[WIDTH-1] ? -y_q : y_q;
                        mag_b   <= bus_w[WIDTH-1] ? -bus_w : bus_w;
                        acc_hi  <= '0;
                        // MUL iterates over the multiplier, DIV over the dividend.
                        acc_lo  <= (dp.op == OP_DIV) ? (y_q[WIDTH-1] ? -y_q : y_q)
                                                     : (bus_w[WIDTH-1] ? -bus_w : bus_w);
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        div0_r  <= 1'b0;
                        state   <= S_RUN;
                    end else if (z_load) begin
                        zlo_r <= alu;
                        zhi_r <= '0;
                    end
                end
                S_RUN: begin
                    if (eng_div) begin
                        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (eng_div) begin
                        if (mag_b == '0) begin
                            zlo_r  <= '1;
                            zhi_r  <= a_raw;
                            div0_r <= 1'b1;
                        end else begin
                            zlo_r <= quo;
                            zhi_r <= rem;
                        end
                    end else begin
                        {zhi_r, zlo_r} <= prod;
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dp.busy  = busy_r;
    assign dp.done  = done_r;
    assign dp.div0  = div0_r;
    assign dp.zhi_q = zhi_r;
    assign dp.zlo_q = zlo_r;
endmodule

// File: doc/datapath_core_p.md
# datapath_core_p

Parametrised successor of the single-bus CPU datapath. It contains a general-purpose register bank of NREGS × WIDTH bits and the Y, Z (ZHI/ZLO), HI and LO registers. Bus sourcing is one-hot with conflict detection and full-width R0 masking under `ba_out`. Signed multiply and divide run on an iterative multi-cycle engine, so the ALU no longer needs a wide combinational multiplier/divider. It sits between the control unit (which drives the strobes) and the MDR/MAR/memory path (attached through `ext_*`).

## Interface
- WIDTH, 32: data width; must be ≥ 4 and even.
- NREGS, 16: number of general-purpose registers; must be a power of two and ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- reg_in  in  NREGS  per-register load enable from the bus.
- reg_out  in  NREGS  per-register bus-drive request.
- ba_out  in  1  when R0 is the bus source, the bus reads all-zero.
- y_in, z_in, hi_in, lo_in  in  1 each  load enables for Y, Z, HI and LO.
- zhi_out, zlo_out, hi_out, lo_out, ext_out_en  in  1 each  bus-drive requests.
- ext_in  in  WIDTH  external bus source (MDR).
- op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV; 11x reserved, behaves as ADD.
- start  in  1  launches MUL/DIV; ignored for other ops.
- bus  out  WIDTH  current bus value.
- bus_conflict  out  1  more than one drive request is active.
- busy  out  1  mul/div engine running.
- done  out  1  one-cycle pulse when the engine writes Z.
- div0  out  1  sticky divide-by-zero flag.
- zhi_q, zlo_q  out  WIDTH each  Z contents, for observation and the CON logic.

## Operation
- **Bus source selection.** The candidate sources, in priority order, are R0..R(NREGS-1), HI, LO, ZHI, ZLO, EXT.
  - The lowest-index active request wins.
  - `bus_conflict` = more than one request is active (combinational).
  - If no request is active, `bus` = 0.
- **R0 masking.** If R0 is selected and `ba_out` = 1, `bus` = 0 across all WIDTH bits. The stored R0 value is unchanged.
- **Register loads.** Every register whose load enable is high captures `bus` at the edge. Several loads in the same cycle are legal.
- **Single-cycle ops (ADD, SUB, AND, OR).**
  - A = Y, B = `bus`.
  - On `z_in`: ZLO ← result mod 2^WIDTH and ZHI ← 0.
  - SUB computes A − B.
- **MUL/DIV launch.** When `start` is sampled high with `op` = MUL or DIV and `busy` = 0, the engine latches Y as A, `bus` as B, and the op.
  - Operands are signed two's complement.
  - The engine iterates on magnitudes and applies a sign fix-up at the end.
- **MUL result.** {ZHI, ZLO} ← full 2·WIDTH-bit signed product.
- **DIV result.** ZLO ← quotient, truncated toward zero; ZHI ← remainder, carrying the sign of the dividend.
- **Divide by zero (B = 0).**
  - ZLO ← all-ones, ZHI ← A.
  - `div0` ← 1, and it stays set until the next accepted `start` clears it.
- **While busy:** `start` and `z_in` are ignored. All other registers and the bus operate normally.
- **Engine state machine:** IDLE → RUN (WIDTH iterations, with a counter) → FIX (sign fix-up and Z write) → IDLE.

## Timing
- **Reset values.** `clr` sampled high sets every register (R*, Y, ZHI, ZLO, HI, LO) to 0, plus `busy`, `done`, `div0` and the counter, and returns the engine to IDLE.
- **Reset mid-operation.** `clr` aborts a running operation: Z is not written and `done` is not pulsed.
- **Combinational outputs.** `bus` and `bus_conflict` have no reset value; they follow the current inputs and register contents.
- **Single-cycle ops.** The result is visible on `zlo_q` the cycle after the `z_in` edge.
- **MUL/DIV latency.** With `start` accepted at edge E0:
  - `busy` = 1 from after E0 through edge E(WIDTH+1).
  - Z is written at E(WIDTH+1).
  - `busy` = 0 and `done` = 1 for exactly the one cycle after E(WIDTH+1).
  - For WIDTH = 32, that is 33 edges after the start edge.
- **Back-to-back operations.** `start` asserted during the `done` cycle is accepted, since `busy` is already 0.
- **Bus write-read through the same register.** If register Rk drives the bus while `reg_in[k]` is high, Rk reloads its own value.

## Test plan
- **Reset and load.** `clr` → all `*_q` and `bus` = 0. Then drive ext_in = 0x0000_0055 with EXT on the bus and `reg_in[0]` high, then `reg_out[0]` → `bus` = 0x55. Adding `ba_out` = 1 → `bus` = 0.
- **Conflict.** `reg_out[3]` and `reg_out[5]` both high, with R3 = 0x11 and R5 = 0x22 → `bus` = 0x11 and `bus_conflict` = 1.
- **MUL.** Y = −7, bus = 6, MUL + `start` → after 33 edges {ZHI, ZLO} = 0xFFFFFFFF_FFFFFFD6 and `done` pulses once. A `start` issued while `busy` is ignored.
- **DIV.** Y = 100, bus = −7 → ZLO = 0xFFFFFFF2 (−14), ZHI = 2, `div0` = 0.
- **Divide by zero.** Y = 9, bus = 0 → ZLO = 0xFFFFFFFF, ZHI = 9, `div0` = 1. The next accepted `start` clears `div0`.
- **Reset mid-operation and parameter sweep.**
  - `clr` asserted 10 cycles into a MUL → `busy` = 0, no `done` pulse, Z = 0.
  - Rerun the MUL and DIV checks with WIDTH = 8, NREGS = 4: (−7)·6 = 0xFFD6, and the result lands 9 edges after start.
